// File: rtl/dispatch_stage_pkg.sv
// Shared opcode encoding, tag-0 "ready" encoding and the RV32I decode helper
// used by the dispatch stage.
package dispatch_stage_pkg;

   localparam int INST_NAME_W = 6;
   localparam int TAG_READY   = 0;

   typedef enum logic [INST_NAME_W-1:0] {
      NOP = 6'd0, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
   } inst_name_e;

   typedef struct packed {
      inst_name_e  name;
      logic [4:0]  rd;
      logic [31:0] imm;
   } dec_t;

   // Anything not recognised decodes to NOP and is dropped at dispatch.
   function automatic dec_t decode(input logic [31:0] inst);
      dec_t       d;
      logic [2:0] f3;
      f3     = inst[14:12];
      d.name = NOP;
      d.rd   = inst[11:7];
      d.imm  = '0;
      case (inst[6:0])
         7'b0110111: begin d.name = LUI;   d.imm = {inst[31:12], 12'b0}; end
         7'b0010111: begin d.name = AUIPC; d.imm = {inst[31:12], 12'b0}; end
         7'b1101111: begin
            d.name = JAL;
            d.imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         7'b1100111: begin d.name = JALR; d.imm = {{20{inst[31]}}, inst[31:20]}; end
         7'b1100011: begin
            case (f3)
               3'b000:  d.name = BEQ;
               3'b001:  d.name = BNE;
               3'b100:  d.name = BLT;
               3'b101:  d.name = BGE;
               3'b110:  d.name = BLTU;
               3'b111:  d.name = BGEU;
               default: d.name = NOP;
            endcase
            d.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         7'b0000011: begin
            case (f3)
               3'b000:  d.name = LB;
               3'b001:  d.name = LH;
               3'b010:  d.name = LW;
               3'b100:  d.name = LBU;
               3'b101:  d.name = LHU;
               default: d.name = NOP;
            endcase
            d.imm = {{20{inst[31]}}, inst[31:20]};
         end
         7'b0100011: begin
            case (f3)
               3'b000:  d.name = SB;
               3'b001:  d.name = SH;
               3'b010:  d.name = SW;
               default: d.name = NOP;
            endcase
            d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         7'b0010011: begin
            case (f3)
               3'b000:  d.name = ADDI;
               3'b010:  d.name = SLTI;
               3'b011:  d.name = SLTIU;
               3'b100:  d.name = XORI;
               3'b110:  d.name = ORI;
               3'b111:  d.name = ANDI;
               3'b001:  d.name = SLLI;
               default: d.name = inst[30] ? SRAI : SRLI;
            endcase
            d.imm = {{20{inst[31]}}, inst[31:20]};
         end
         7'b0110011: begin
            case (f3)
               3'b000:  d.name = inst[30] ? SUB : ADD;
               3'b001:  d.name = SLL;
               3'b010:  d.name = SLT;
               3'b011:  d.name = SLTU;
               3'b100:  d.name = XOR;
               3'b101:  d.name = inst[30] ? SRA : SRL;
               3'b110:  d.name = OR;
               default: d.name = AND;
            endcase
         end
         default: d.name = NOP;
      endcase
      // Branches and stores write no register.
      if (inst[6:0] == 7'b1100011 || inst[6:0] == 7'b0100011) d.rd = '0;
      return d;
   endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Issue bus from the dispatch stage to the RoB/RS/LSB, including the
// downstream ready signals.
interface dispatch_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   import dispatch_stage_pkg::*;

   logic                   issue_valid_out;
   logic                   issue_fire_out;
   logic                   issue_to_lsb_out;
   logic [INST_NAME_W-1:0] inst_name_out;
   logic [4:0]             rd_out;
   logic [TAG_W-1:0]       tag_out;
   logic [TAG_W-1:0]       q1_out;
   logic [TAG_W-1:0]       q2_out;
   logic [XLEN-1:0]        v1_out;
   logic [XLEN-1:0]        v2_out;
   logic [XLEN-1:0]        imm_out;
   logic [XLEN-1:0]        pc_out;
   logic [XLEN-1:0]        rollback_pc_out;
   logic                   is_jump_out;
   logic                   is_store_out;
   logic                   predicted_jump_out;
   logic                   rob_ready_in;
   logic                   rs_ready_in;
   logic                   lsb_ready_in;

   modport master (
      output issue_valid_out, issue_fire_out, issue_to_lsb_out, inst_name_out,
             rd_out, tag_out, q1_out, q2_out, v1_out, v2_out, imm_out, pc_out,
             rollback_pc_out, is_jump_out, is_store_out, predicted_jump_out,
      input  rob_ready_in, rs_ready_in, lsb_ready_in
   );

   modport slave (
      input  issue_valid_out, issue_fire_out, issue_to_lsb_out, inst_name_out,
             rd_out, tag_out, q1_out, q2_out, v1_out, v2_out, imm_out, pc_out,
             rollback_pc_out, is_jump_out, is_store_out, predicted_jump_out,
      output rob_ready_in, rs_ready_in, lsb_ready_in
   );

endinterface

// File: rtl/dispatch_stage_operand_resolve.sv
// Combinational operand forwarding: lowest-index matching CDB, then RoB, then
// the RegFile value. A zero tag is already ready and is never forwarded.
module dispatch_stage_operand_resolve
   import dispatch_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int NUM_CDB = 2
) (
   input  logic [TAG_W-1:0]         q_reg_in,
   input  logic [XLEN-1:0]          v_reg_in,
   input  logic                     rob_ready_in,
   input  logic [XLEN-1:0]          v_rob_in,
   input  logic [NUM_CDB-1:0]       cdb_valid_in,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_in,
   input  logic [NUM_CDB*XLEN-1:0]  cdb_data_in,
   output logic [TAG_W-1:0]         q_out,
   output logic [XLEN-1:0]          v_out
);

   always_comb begin
      q_out = q_reg_in;
      v_out = v_reg_in;
      if (q_reg_in != TAG_W'(TAG_READY)) begin
         if (rob_ready_in) begin
            q_out = TAG_W'(TAG_READY);
            v_out = v_rob_in;
         end
         // Scan downwards so the lowest-index CDB hit is the last assignment.
         for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid_in[i] && (cdb_tag_in[i*TAG_W +: TAG_W] == q_reg_in)) begin
               q_out = TAG_W'(TAG_READY);
               v_out = cdb_data_in[i*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/dispatch_stage.sv
// One-entry decode/issue register between fetch and RoB/RS/LSB with CDB snooping.
// Optional DISPATCH_PERF_EN adds issued/stall counters (tied to 0 otherwise).
module dispatch_stage
   import dispatch_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int NUM_CDB = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     fetch_valid_in,
   output logic                     fetch_ready_out,
   input  logic [31:0]              inst_in,
   input  logic [XLEN-1:0]          pc_in,
   input  logic [XLEN-1:0]          rollback_pc_in,
   input  logic                     predicted_jump_in,
   input  logic [TAG_W-1:0]         rob_tag_in,
   output logic [4:0]               rs1_out,
   output logic [4:0]               rs2_out,
   input  logic [TAG_W-1:0]         q1_reg_in,
   input  logic [TAG_W-1:0]         q2_reg_in,
   input  logic [XLEN-1:0]          v1_reg_in,
   input  logic [XLEN-1:0]          v2_reg_in,
   output logic [TAG_W-1:0]         q1_rob_out,
   output logic [TAG_W-1:0]         q2_rob_out,
   input  logic                     q1_rob_ready_in,
   input  logic                     q2_rob_ready_in,
   input  logic [XLEN-1:0]          v1_rob_in,
   input  logic [XLEN-1:0]          v2_rob_in,
   input  logic [NUM_CDB-1:0]       cdb_valid_in,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_in,
   input  logic [NUM_CDB*XLEN-1:0]  cdb_data_in,
   input  logic                     flush_in,
   output logic [31:0]              issued_cnt_out,
   output logic [31:0]              stall_cnt_out,
   dispatch_stage_if.master         issue_if
);

   dec_t             dec;
   logic [XLEN-1:0]  imm_ext;
   logic             tgt_rdy, issue_valid, fire, fetch_ready, new_entry;
   logic [TAG_W-1:0] q1_cap, q2_cap, q1_snp, q2_snp;
   logic [XLEN-1:0]  v1_cap, v2_cap, v1_snp, v2_snp;

   logic             valid_q, valid_d, to_lsb_q, to_lsb_d;
   inst_name_e       inst_name_q, inst_name_d;
   logic [4:0]       rd_q, rd_d;
   logic [TAG_W-1:0] tag_q, tag_d, q1_q, q1_d, q2_q, q2_d;
   logic [XLEN-1:0]  v1_q, v1_d, v2_q, v2_d, imm_q, imm_d;
   logic [XLEN-1:0]  pc_q, pc_d, rb_pc_q, rb_pc_d;
   logic             is_jump_q, is_jump_d, is_store_q, is_store_d;
   logic             pred_jump_q, pred_jump_d;

   assign dec        = decode(inst_in);
   assign imm_ext    = XLEN'($signed(dec.imm));
   assign rs1_out    = inst_in[19:15];
   assign rs2_out    = inst_in[24:20];
   assign q1_rob_out = q1_reg_in;
   assign q2_rob_out = q2_reg_in;

   // Capture-time resolution for the incoming instruction.
   dispatch_stage_operand_resolve #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cap1 (
      .q_reg_in(q1_reg_in), .v_reg_in(v1_reg_in), .rob_ready_in(q1_rob_ready_in),
      .v_rob_in(v1_rob_in), .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
      .cdb_data_in(cdb_data_in), .q_out(q1_cap), .v_out(v1_cap));
   dispatch_stage_operand_resolve #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cap2 (
      .q_reg_in(q2_reg_in), .v_reg_in(v2_reg_in), .rob_ready_in(q2_rob_ready_in),
      .v_rob_in(v2_rob_in), .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
      .cdb_data_in(cdb_data_in), .q_out(q2_cap), .v_out(v2_cap));

   // Hold snoop keeps a stalled entry's tags current; only the CDBs apply here.
   dispatch_stage_operand_resolve #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_snp1 (
      .q_reg_in(q1_q), .v_reg_in(v1_q), .rob_ready_in(1'b0), .v_rob_in('0),
      .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
      .q_out(q1_snp), .v_out(v1_snp));
   dispatch_stage_operand_resolve #(.XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_snp2 (
      .q_reg_in(q2_q), .v_reg_in(v2_q), .rob_ready_in(1'b0), .v_rob_in('0),
      .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
      .q_out(q2_snp), .v_out(v2_snp));

   assign tgt_rdy         = to_lsb_q ? issue_if.lsb_ready_in : issue_if.rs_ready_in;
   assign issue_valid     = valid_q & rdy_in;
   assign fire            = issue_valid & issue_if.rob_ready_in & tgt_rdy & ~flush_in;
   assign fetch_ready     = rdy_in & ~flush_in & (~valid_q | fire);
   assign new_entry       = fetch_valid_in & fetch_ready & (dec.name != NOP);
   assign fetch_ready_out = fetch_ready;

   always_comb begin
      valid_d     = valid_q;     to_lsb_d   = to_lsb_q;   inst_name_d = inst_name_q;
      rd_d        = rd_q;        tag_d      = tag_q;      imm_d       = imm_q;
      q1_d        = q1_q;        q2_d       = q2_q;       v1_d        = v1_q;
      v2_d        = v2_q;        pc_d       = pc_q;       rb_pc_d     = rb_pc_q;
      is_jump_d   = is_jump_q;   is_store_d = is_store_q; pred_jump_d = pred_jump_q;
      if (flush_in) begin
         valid_d = 1'b0;
      end else if (rdy_in) begin
         if (fire) begin
            valid_d = 1'b0;
         end else if (valid_q) begin
            q1_d = q1_snp; v1_d = v1_snp;
            q2_d = q2_snp; v2_d = v2_snp;
         end
         if (new_entry) begin
            valid_d     = 1'b1;
            inst_name_d = dec.name;
            rd_d        = dec.rd;
            imm_d       = imm_ext;
            tag_d       = rob_tag_in;
            q1_d        = q1_cap; v1_d = v1_cap;
            q2_d        = q2_cap; v2_d = v2_cap;
            pc_d        = pc_in;
            rb_pc_d     = rollback_pc_in;
            pred_jump_d = predicted_jump_in;
            to_lsb_d    = (dec.name >= LB) && (dec.name <= SW);
            is_store_d  = (dec.name >= SB) && (dec.name <= SW);
            is_jump_d   = (dec.name >= JAL) && (dec.name <= BGEU);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= 1'b0;  to_lsb_q <= 1'b0;  inst_name_q <= NOP;  rd_q <= '0;
         tag_q   <= '0;    imm_q    <= '0;    q1_q        <= '0;   q2_q <= '0;
         v1_q    <= '0;    v2_q     <= '0;    pc_q        <= '0;   rb_pc_q <= '0;
         is_jump_q <= 1'b0; is_store_q <= 1'b0; pred_jump_q <= 1'b0;
      end else begin
         valid_q <= valid_d;  to_lsb_q <= to_lsb_d;  inst_name_q <= inst_name_d;
         rd_q    <= rd_d;     tag_q    <= tag_d;     imm_q       <= imm_d;
         q1_q    <= q1_d;     q2_q     <= q2_d;      v1_q        <= v1_d;
         v2_q    <= v2_d;     pc_q     <= pc_d;      rb_pc_q     <= rb_pc_d;
         is_jump_q <= is_jump_d; is_store_q <= is_store_d; pred_jump_q <= pred_jump_d;
      end
   end

   assign issue_if.issue_valid_out    = issue_valid;
   assign issue_if.issue_fire_out     = fire;
   assign issue_if.issue_to_lsb_out   = to_lsb_q;
   assign issue_if.inst_name_out      = inst_name_q;
   assign issue_if.rd_out             = rd_q;
   assign issue_if.tag_out            = tag_q;
   assign issue_if.q1_out             = q1_q;
   assign issue_if.q2_out             = q2_q;
   assign issue_if.v1_out             = v1_q;
   assign issue_if.v2_out             = v2_q;
   assign issue_if.imm_out            = imm_q;
   assign issue_if.pc_out             = pc_q;
   assign issue_if.rollback_pc_out    = rb_pc_q;
   assign issue_if.is_jump_out        = is_jump_q;
   assign issue_if.is_store_out       = is_store_q;
   assign issue_if.predicted_jump_out = pred_jump_q;

`ifdef DISPATCH_PERF_EN
   logic [31:0] issued_cnt_q, issued_cnt_d, stall_cnt_q, stall_cnt_d;

   always_comb begin
      issued_cnt_d = issued_cnt_q + 32'(fire);
      stall_cnt_d  = stall_cnt_q + 32'(issue_valid & ~fire);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         issued_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         issued_cnt_q <= issued_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign issued_cnt_out = issued_cnt_q;
   assign stall_cnt_out  = stall_cnt_q;
`else
   assign issued_cnt_out = '0;
   assign stall_cnt_out  = '0;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: a decode/forwarding vector table plus
// hand sequences for stall, hold snoop, flush and reset-mid-stall.
module tb_dispatch_stage;
   import dispatch_stage_pkg::*;

`ifdef DISPATCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, rdy, fetch_valid, fetch_ready, pred_jump, q1_rob_rdy, q2_rob_rdy, flush;
   logic [31:0] inst, pc, rb_pc, v1_reg, v2_reg, v1_rob, v2_rob, issued_cnt, stall_cnt;
   logic [4:0]  rob_tag, rs1, rs2, q1_reg, q2_reg, q1_rob, q2_rob;
   logic [1:0]  cdb_valid;
   logic [9:0]  cdb_tag;
   logic [63:0] cdb_data;

   int n_cmp = 0;
   int n_bad = 0;
   int fires;

   dispatch_stage_if #(.XLEN(32), .TAG_W(5)) ifc ();

   dispatch_stage #(.XLEN(32), .TAG_W(5), .NUM_CDB(2)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
      .fetch_valid_in(fetch_valid), .fetch_ready_out(fetch_ready),
      .inst_in(inst), .pc_in(pc), .rollback_pc_in(rb_pc), .predicted_jump_in(pred_jump),
      .rob_tag_in(rob_tag), .rs1_out(rs1), .rs2_out(rs2),
      .q1_reg_in(q1_reg), .q2_reg_in(q2_reg), .v1_reg_in(v1_reg), .v2_reg_in(v2_reg),
      .q1_rob_out(q1_rob), .q2_rob_out(q2_rob),
      .q1_rob_ready_in(q1_rob_rdy), .q2_rob_ready_in(q2_rob_rdy),
      .v1_rob_in(v1_rob), .v2_rob_in(v2_rob),
      .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_data_in(cdb_data),
      .flush_in(flush), .issued_cnt_out(issued_cnt), .stall_cnt_out(stall_cnt),
      .issue_if(ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  q1r, q2r;
      logic [31:0] v1r, v2r;
      logic        r1, r2;
      logic [31:0] v1rob, v2rob;
      logic [1:0]  cv;
      logic [4:0]  t0, t1;
      logic [31:0] d0, d1;
      logic        evld, elsb;
      logic [5:0]  ename;
      logic [4:0]  erd;
      logic [31:0] eimm;
      logic [4:0]  eq1;
      logic [31:0] ev1;
      logic [4:0]  eq2;
      logic [31:0] ev2;
      logic        ejmp, est;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_ops(input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] va, input logic [31:0] vb);
      q1_reg = a; q2_reg = b; v1_reg = va; v2_reg = vb;
      q1_rob_rdy = 1'b0; q2_rob_rdy = 1'b0; cdb_valid = 2'b00;
   endtask

   initial begin
      //          inst          q1r q2r v1r     v2r    r1 r2 v1rob   v2rob   cv     t0 t1 d0      d1      vld lsb name rd imm          eq1 ev1     eq2 ev2     jmp st
      tbl[0] = '{32'h002081B3, 0,  0,  32'd5,  32'd7, 0, 0, 32'h0,  32'h0,  2'b00, 0, 0, 32'h0,  32'h0,  1, 0, ADD,  3, 32'h0,       0, 32'd5,  0, 32'd7,  0, 0};
      tbl[1] = '{32'h00802283, 3,  0,  32'hAAA,32'h55,1, 0, 32'h100,32'h999,2'b00, 0, 0, 32'h0,  32'h0,  1, 1, LW,   5, 32'd8,       0, 32'h100,0, 32'h55, 0, 0};
      tbl[2] = '{32'h0020A623, 6,  9,  32'h1,  32'h77,0, 0, 32'h0,  32'h0,  2'b11, 6, 6, 32'h11, 32'h22, 1, 1, SW,   0, 32'd12,      0, 32'h11, 9, 32'h77, 0, 1};
      tbl[3] = '{32'h40208233, 2,  7,  32'h1,  32'h33,1, 0, 32'h999,32'h0,  2'b10, 0, 2, 32'h0,  32'hAB, 1, 0, SUB,  4, 32'h0,       0, 32'hAB, 7, 32'h33, 0, 0};
      tbl[4] = '{32'hFFF08313, 0,  0,  32'h42, 32'h0, 0, 0, 32'h0,  32'h0,  2'b01, 0, 0, 32'hEE, 32'h0,  1, 0, ADDI, 6, 32'hFFFFFFFF,0, 32'h42, 0, 32'h0,  0, 0};
      tbl[5] = '{32'h00208863, 5,  4,  32'h10, 32'h20,0, 1, 32'h0,  32'h444,2'b00, 5, 0, 32'h5,  32'h0,  1, 0, BEQ,  0, 32'd16,      5, 32'h10, 0, 32'h444,1, 0};
      tbl[6] = '{32'h123453B7, 0,  0,  32'h0,  32'h0, 0, 0, 32'h0,  32'h0,  2'b00, 0, 0, 32'h0,  32'h0,  1, 0, LUI,  7, 32'h12345000,0, 32'h0,  0, 32'h0,  0, 0};
      tbl[7] = '{32'h00000000, 0,  0,  32'h0,  32'h0, 0, 0, 32'h0,  32'h0,  2'b00, 0, 0, 32'h0,  32'h0,  0, 0, NOP,  0, 32'h0,       0, 32'h0,  0, 32'h0,  0, 0};

      rst_n = 1'b0; rdy = 1'b1; fetch_valid = 1'b0; inst = '0; pc = '0; rb_pc = '0;
      pred_jump = 1'b0; rob_tag = '0; flush = 1'b0; v1_rob = '0; v2_rob = '0;
      cdb_tag = '0; cdb_data = '0;
      set_ops(0, 0, 0, 0);
      ifc.rob_ready_in = 1'b1; ifc.rs_ready_in = 1'b1; ifc.lsb_ready_in = 1'b1;

      #1;
      chk("rst_issue_valid", ifc.issue_valid_out, 0);
      chk("rst_tag", ifc.tag_out, 0);
      chk("rst_v1", ifc.v1_out, 0);
      chk("rst_cnt", {issued_cnt, stall_cnt}, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("rel_fetch_ready", fetch_ready, 1);

      // Decode and operand-resolution table; every entry fires the cycle after capture.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         inst = tbl[i].inst; q1_reg = tbl[i].q1r; q2_reg = tbl[i].q2r;
         v1_reg = tbl[i].v1r; v2_reg = tbl[i].v2r; q1_rob_rdy = tbl[i].r1; q2_rob_rdy = tbl[i].r2;
         v1_rob = tbl[i].v1rob; v2_rob = tbl[i].v2rob; cdb_valid = tbl[i].cv;
         cdb_tag = {tbl[i].t1, tbl[i].t0}; cdb_data = {tbl[i].d1, tbl[i].d0};
         pc = 32'h1000 + 32'(i * 4); rb_pc = pc + 32'h100; rob_tag = 5'(i + 1);
         pred_jump = (i % 2) == 1; fetch_valid = 1'b1;
         @(negedge clk);
         fetch_valid = 1'b0; cdb_valid = 2'b00;
         #1;
         chk($sformatf("v%0d_valid", i), ifc.issue_valid_out, tbl[i].evld);
         chk($sformatf("v%0d_fire", i), ifc.issue_fire_out, tbl[i].evld);
         if (tbl[i].evld) begin
            chk($sformatf("v%0d_name", i), ifc.inst_name_out, tbl[i].ename);
            chk($sformatf("v%0d_lsb", i), ifc.issue_to_lsb_out, tbl[i].elsb);
            chk($sformatf("v%0d_rd", i), ifc.rd_out, tbl[i].erd);
            chk($sformatf("v%0d_imm", i), ifc.imm_out, tbl[i].eimm);
            chk($sformatf("v%0d_q1v1", i), {ifc.q1_out, ifc.v1_out}, {tbl[i].eq1, tbl[i].ev1});
            chk($sformatf("v%0d_q2v2", i), {ifc.q2_out, ifc.v2_out}, {tbl[i].eq2, tbl[i].ev2});
            chk($sformatf("v%0d_flags", i), {ifc.is_jump_out, ifc.is_store_out, ifc.predicted_jump_out},
                {tbl[i].ejmp, tbl[i].est, logic'((i % 2) == 1)});
            chk($sformatf("v%0d_tag", i), ifc.tag_out, 5'(i + 1));
            chk($sformatf("v%0d_pcs", i), {ifc.pc_out, ifc.rollback_pc_out},
                {32'h1000 + 32'(i * 4), 32'h1100 + 32'(i * 4)});
         end
      end
      @(negedge clk); #1;
      chk("tbl_issued_cnt", issued_cnt, PERF ? 7 : 0);

      // LW stalled on a full LSB for three cycles, then a rdy_in freeze.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      @(negedge clk);
      inst = 32'h00802283; set_ops(0, 0, 32'h1, 32'h2); rob_tag = 5'd3;
      ifc.lsb_ready_in = 1'b0; fetch_valid = 1'b1;
      @(negedge clk); fetch_valid = 1'b0; #1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("stall%0d_held", c), {ifc.issue_valid_out, ifc.issue_fire_out, fetch_ready}, 3'b100);
         @(negedge clk); #1;
      end
      chk("stall_cnt3", stall_cnt, PERF ? 3 : 0);
      rdy = 1'b0; ifc.lsb_ready_in = 1'b1; #1;
      chk("rdy_low_frozen", {ifc.issue_valid_out, ifc.issue_fire_out, fetch_ready}, 3'b000);
      @(negedge clk); rdy = 1'b1; #1;
      chk("rdy_back_fire", {ifc.issue_valid_out, ifc.issue_fire_out, ifc.tag_out}, {2'b11, 5'd3});
      @(negedge clk); #1;
      chk("stall_done", {ifc.issue_valid_out, issued_cnt, stall_cnt}, {1'b0, PERF ? 32'd1 : 32'd0, PERF ? 32'd3 : 32'd0});

      // Hold snoop: CDB1 resolves a pending tag; CDB0 tag 0 must be ignored.
      inst = 32'h002081B3; set_ops(5'd4, 5'd0, 32'h1, 32'h9);
      ifc.rob_ready_in = 1'b0; fetch_valid = 1'b1;
      @(negedge clk); fetch_valid = 1'b0; #1;
      chk("snoop_pre", {ifc.q1_out, ifc.v1_out}, {5'd4, 32'h1});
      cdb_valid = 2'b11; cdb_tag = {5'd4, 5'd0}; cdb_data = {32'hDEAD, 32'hBAD};
      @(negedge clk); cdb_valid = 2'b00; #1;
      chk("snoop_q1v1", {ifc.q1_out, ifc.v1_out}, {5'd0, 32'hDEAD});
      chk("snoop_q2v2", {ifc.q2_out, ifc.v2_out}, {5'd0, 32'h9});
      chk("snoop_still_held", ifc.issue_valid_out, 1);
      ifc.rob_ready_in = 1'b1;
      @(negedge clk); #1;
      chk("snoop_drained", ifc.issue_valid_out, 0);

      // Flush beats both the pending fire and the offered capture.
      inst = 32'h002081B3; set_ops(0, 0, 32'h3, 32'h4); rob_tag = 5'd10;
      ifc.rob_ready_in = 1'b0; fetch_valid = 1'b1;
      @(negedge clk);
      inst = 32'h40208233; rob_tag = 5'd11; flush = 1'b1; ifc.rob_ready_in = 1'b1; #1;
      chk("flush_no_fire", {ifc.issue_fire_out, fetch_ready}, 2'b00);
      @(negedge clk); flush = 1'b0; fetch_valid = 1'b0; #1;
      chk("flush_cleared", ifc.issue_valid_out, 0);
      chk("flush_no_capture", {ifc.tag_out, ifc.inst_name_out}, {5'd10, ADD});

      // Reset pulse mid-stall, then 20 back-to-back ADDs.
      inst = 32'h00802283; set_ops(0, 0, 32'h7, 32'h8); rob_tag = 5'd12;
      ifc.lsb_ready_in = 1'b0; fetch_valid = 1'b1;
      @(negedge clk); fetch_valid = 1'b0;
      @(negedge clk); #2; rst_n = 1'b0; #1;
      chk("midrst_clear", {ifc.issue_valid_out, ifc.tag_out, ifc.inst_name_out, ifc.v2_out}, 0);
      chk("midrst_imm_lsb", {ifc.imm_out, ifc.issue_to_lsb_out}, 0);
      chk("midrst_cnt", {issued_cnt, stall_cnt}, 0);
      @(negedge clk); rst_n = 1'b1; ifc.lsb_ready_in = 1'b1; #1;
      chk("midrst_fetch_ready", fetch_ready, 1);
      inst = 32'h002081B3; set_ops(0, 0, 32'd5, 32'd7); fetch_valid = 1'b1;
      fires = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rob_tag = 5'(c + 1);
         if (c == 19) fetch_valid = 1'b0;
         #1;
         if (ifc.issue_fire_out) fires++;
      end
      @(negedge clk); #1;
      chk("b2b_fires", fires, 20);
      chk("b2b_empty", ifc.issue_valid_out, 0);
      chk("b2b_counters", {issued_cnt, stall_cnt}, {PERF ? 32'd20 : 32'd0, 32'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
